// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int DATA_BITS              = 8;
    localparam int FRAME_BITS             = 11;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a pop frees a slot for a push in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw pins, decodes 11-bit frames
// and buffers good scan codes in a FIFO for the CPU.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    data_out,
    output logic                          int_req,
    output logic                          overflow,
    output logic                          frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int BW = $clog2(DATA_BITS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_s1, clk_s2, clk_hist;
    logic data_s1, data_s2;
    logic fall;

    ps2_state_t             state, state_next;
    logic [DATA_BITS-1:0]   shift, shift_next;
    logic [BW-1:0]          bit_cnt, bit_cnt_next;
    logic                   parity_bit, parity_next;
    logic [TW-1:0]          tcnt;
    logic                   timeout;
    logic                   frame_good;
    logic                   frame_bad;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Idle-high reset keeps the edge detector quiet while the bus is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_hist <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_hist <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall    = clk_hist && !clk_s2;
    assign timeout = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            tcnt       <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_cnt    <= bit_cnt_next;
            parity_bit <= parity_next;
            frame_err  <= frame_bad;
            if (state == IDLE || fall || timeout) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
            // A full FIFO still accepts the byte if a pop lands in the same cycle.
            if (frame_good && fifo_full && !rd_en) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_bit;
        frame_good   = 1'b0;
        frame_bad    = 1'b0;
        if (timeout) begin
            state_next = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_s2) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next   = {data_s2, shift[DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = data_s2;
                    state_next  = STOP;
                end
                STOP: begin
                    if (data_s2 && (^{shift, parity_bit})) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (frame_good),
        .rd_en   (rd_en),
        .wr_data (shift),
        .rd_data (data_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign int_req = !fifo_empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are bit-banged on the PS/2 pins at a
// scaled-down bus rate and received bytes are checked against a queue model.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       int_req;
    logic       overflow;
    logic       frame_err;
    logic [3:0] count;

    int         tests_run = 0;
    int         tests_failed = 0;
    int         err_cycles = 0;
    int         exp_err = 0;
    logic       exp_overflow = 1'b0;
    logic [7:0] sb[$];

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .int_req   (int_req),
        .overflow  (overflow),
        .frame_err (frame_err),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err === 1'b1) err_cycles++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkFlags(input string tag);
        @(negedge clk);
        checkOutput({tag, "_count"}, 32'(count), 32'(sb.size()));
        checkOutput({tag, "_int_req"}, 32'(int_req), 32'(sb.size() != 0));
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'(exp_overflow));
        checkOutput({tag, "_err_cycles"}, 32'(err_cycles), 32'(exp_err));
        checkOutput({tag, "_data_out"}, 32'(data_out), (sb.size() != 0) ? 32'(sb[0]) : 32'h0);
    endtask

    task automatic popAndCheck();
        logic [7:0] exp_byte;
        @(negedge clk);
        exp_byte = sb.pop_front();
        checkOutput("pop_int_req", 32'(int_req), 32'h1);
        checkOutput("pop_data_out", 32'(data_out), 32'(exp_byte));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput("pop_count_after", 32'(count), 32'(sb.size()));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_overflow = 1'b0;
    endtask

    // Sends the first nbits of a frame; bits change while ps2_clk is high.
    task automatic applyStimulus(input logic [7:0] b, input bit bad_parity, input logic stop,
                                 input int nbits, input bit rd_on_stop, input bit hold_low);
        logic [10:0] bits;
        logic        par;
        par  = (~^b) ^ bad_parity;
        bits = {stop, par, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10 && rd_on_stop) begin
                repeat (2) @(negedge clk);
                checkOutput("coincident_head", 32'(data_out), 32'(sb[0]));
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (!(i == nbits - 1 && hold_low)) ps2_clk = 1'b1;
        end
        if (nbits == 11) begin
            if (stop && !bad_parity) begin
                if (rd_on_stop) begin
                    void'(sb.pop_front());
                    sb.push_back(b);
                end else if (sb.size() < DEPTH) begin
                    sb.push_back(b);
                end else begin
                    exp_overflow = 1'b1;
                end
            end else begin
                exp_err++;
            end
            ps2_data = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        checkFlags("reset");

        applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        checkFlags("single_1c");
        popAndCheck();
        checkFlags("single_drained");

        applyStimulus(8'hF0, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        checkFlags("pair");
        popAndCheck();
        popAndCheck();

        applyStimulus(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        checkFlags("bad_parity");
        applyStimulus(8'h1C, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        checkFlags("bad_stop");

        for (int i = 0; i < 9; i++) applyStimulus(8'hA0 + 8'(i), 1'b0, 1'b1, 11, 1'b0, 1'b0);
        checkFlags("overflow_fill");
        for (int i = 0; i < DEPTH; i++) popAndCheck();
        checkFlags("overflow_drained");

        doReset();
        checkFlags("reset_again");
        for (int i = 0; i < DEPTH; i++) applyStimulus(8'h30 + 8'(i), 1'b0, 1'b1, 11, 1'b0, 1'b0);
        checkFlags("refill");
        applyStimulus(8'h55, 1'b0, 1'b1, 11, 1'b1, 1'b0);
        checkFlags("full_pop_push");
        for (int i = 0; i < DEPTH; i++) popAndCheck();

        applyStimulus(8'h1C, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 50) @(negedge clk);
        checkFlags("timeout");
        applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        checkFlags("after_timeout");
        popAndCheck();

        applyStimulus(8'h1C, 1'b0, 1'b1, 5, 1'b0, 1'b1);
        doReset();
        repeat (10) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (TIMEOUT + 50) @(negedge clk);
        checkFlags("mid_frame_reset");
        applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        checkFlags("after_reset_frame");
        popAndCheck();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
